// File: rtl/vterm_pkg.sv
// Shared constants and state encoding for the vterm text terminal.
// Control codes, FSM states and the blank cell value.
package vterm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    SCROLL,
    CLEAR
  } state_t;

  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] BLANK  = 8'h20;

  function automatic logic [15:0] blank_cell(
    input logic [7:0] attr
  );
    return {attr, BLANK};
  endfunction

  function automatic logic writes_cell(
    input logic [7:0] b
  );
    return !(b == CC_CR || b == CC_LF ||
             b == CC_BS || b == CC_FF);
  endfunction

endpackage

// File: rtl/vterm_scroller.sv
// Bulk RAM mover: line-up copy plus bottom-line fill, or full clear.
// Copy writes lag reads by one clk; done is asserted on the last write.
module vterm_scroller
  import vterm_pkg::*;
#(
  parameter int          SCR_STRIDE = 128,
  parameter int          SCR_WIDTH  = 80,
  parameter int          SCR_HEIGHT = 56,
  parameter int          ADDR_W     = 13,
  parameter logic [7:0]  ATTR       = 8'h1F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [15:0]       q,
  output logic [ADDR_W-1:0] radr,
  output logic [ADDR_W-1:0] wadr,
  output logic [15:0]       wdata,
  output logic              wr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(SCR_STRIDE);
  localparam logic [ADDR_W-1:0] LAST_RD =
    ADDR_W'(SCR_HEIGHT * SCR_STRIDE - 1);
  localparam logic [ADDR_W-1:0] FILL_BASE =
    ADDR_W'((SCR_HEIGHT - 1) * SCR_STRIDE);
  localparam logic [ADDR_W-1:0] FILL_LAST =
    ADDR_W'(SCR_WIDTH - 1);

  logic              rd_on;
  logic              cp_wr;
  logic              fill_on;
  logic              clr;
  logic [ADDR_W-1:0] prev;
  logic [ADDR_W-1:0] cnt;

  assign done  = fill_on &&
                 (cnt == (clr ? LAST_RD : FILL_LAST));
  assign wr    = cp_wr | fill_on;
  assign wadr  = cp_wr ? prev - STRIDE
                       : (clr ? '0 : FILL_BASE) + cnt;
  assign wdata = cp_wr ? q : blank_cell(ATTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      radr    <= '0;
      rd_on   <= 1'b0;
      cp_wr   <= 1'b0;
      fill_on <= 1'b0;
      clr     <= 1'b0;
      prev    <= '0;
      cnt     <= '0;
    end else if (start) begin
      clr <= mode;
      cnt <= '0;
      if (mode) begin
        fill_on <= 1'b1;
      end else begin
        radr  <= STRIDE;
        rd_on <= 1'b1;
      end
    end else begin
      cp_wr <= rd_on;
      if (rd_on) begin
        prev <= radr;
        if (radr == LAST_RD) rd_on <= 1'b0;
        else                 radr  <= radr + 1'b1;
      end
      // last copy write retires: switch to the bottom-line fill
      if (cp_wr && !rd_on) begin
        fill_on <= 1'b1;
        cnt     <= '0;
      end
      if (fill_on) begin
        if (done) fill_on <= 1'b0;
        else      cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vterm.sv
// Text terminal: pops FIFO bytes, writes cells at the cursor on the
// bottom line, handles CR/LF/BS/TAB/FF, auto-wrap, scroll and clear.
module vterm
  import vterm_pkg::*;
#(
  parameter int          SCR_STRIDE = 128,
  parameter int          SCR_WIDTH  = 80,
  parameter int          SCR_HEIGHT = 56,
  parameter int          ADDR_W     = 13,
  parameter int          TAB_W      = 4,
  parameter logic [7:0]  ATTR       = 8'h1F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rdata,
  input  logic              rdempty,
  output logic              ack,
  output logic [ADDR_W-1:0] radr,
  input  logic [15:0]       q,
  output logic [ADDR_W-1:0] wadr,
  output logic [15:0]       wdata,
  output logic              wr,
  output logic [ADDR_W-1:0] cursor_adr,
  output logic              busy
);

  localparam int CW  = $clog2(SCR_WIDTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [ADDR_W-1:0] LINE_BASE =
    ADDR_W'((SCR_HEIGHT - 1) * SCR_STRIDE);
  localparam logic [CW:0] TAB_MASK = ~CW1'(TAB_W - 1);
  localparam logic [CW:0] COL_END  = CW1'(SCR_WIDTH);

  state_t            state;
  state_t            nstate;
  logic [CW-1:0]     col;
  logic [CW-1:0]     ncol;
  logic [CW:0]       adv;
  logic [7:0]        byte_r;
  logic              dec_wr;
  logic [ADDR_W-1:0] dec_wadr;
  logic [15:0]       dec_wdata;
  logic              sc_start;
  logic              sc_mode;
  logic              sc_wr;
  logic              sc_done;
  logic [ADDR_W-1:0] sc_wadr;
  logic [15:0]       sc_wdata;

  // gated by reset so a queued byte is never popped while held in reset
  assign ack = (state == IDLE) && !rdempty && !reset;
  assign busy       = (state != IDLE);
  assign cursor_adr = LINE_BASE + ADDR_W'(col);

  assign wr    = dec_wr | sc_wr;
  assign wadr  = sc_wr ? sc_wadr  : dec_wadr;
  assign wdata = sc_wr ? sc_wdata : dec_wdata;

  always_comb begin
    ncol   = col;
    nstate = IDLE;
    adv    = '0;
    unique case (1'b1)
      byte_r == CC_CR: ncol = '0;
      byte_r == CC_LF: nstate = SCROLL;
      byte_r == CC_BS:
        ncol = (col == '0) ? col : col - CW'(1);
      byte_r == CC_FF: begin
        ncol   = '0;
        nstate = CLEAR;
      end
      default: begin
        adv = (byte_r == CC_TAB)
            ? (CW1'(col) + CW1'(TAB_W)) & TAB_MASK
            : CW1'(col) + CW1'(1);
        if (adv >= COL_END) begin
          ncol   = '0;
          nstate = SCROLL;
        end else begin
          ncol = adv[CW-1:0];
        end
      end
    endcase
  end

  assign sc_start = (state == DECODE) && (nstate != IDLE);
  assign sc_mode  = (nstate == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      byte_r    <= '0;
      dec_wr    <= 1'b0;
      dec_wadr  <= '0;
      dec_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (!rdempty) begin
          byte_r    <= rdata;
          state     <= DECODE;
          dec_wr    <= writes_cell(rdata);
          dec_wadr  <= cursor_adr;
          dec_wdata <= {ATTR,
                        (rdata == CC_TAB) ? BLANK : rdata};
        end
        DECODE: begin
          dec_wr <= 1'b0;
          col    <= ncol;
          state  <= nstate;
        end
        SCROLL, CLEAR: if (sc_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  vterm_scroller #(
    .SCR_STRIDE (SCR_STRIDE),
    .SCR_WIDTH  (SCR_WIDTH),
    .SCR_HEIGHT (SCR_HEIGHT),
    .ADDR_W     (ADDR_W),
    .ATTR       (ATTR)
  ) u_scroller (
    .clk   (clk),
    .reset (reset),
    .start (sc_start),
    .mode  (sc_mode),
    .q     (q),
    .radr  (radr),
    .wadr  (sc_wadr),
    .wdata (sc_wdata),
    .wr    (sc_wr),
    .done  (sc_done)
  );

endmodule

// File: tb/tb_vterm.sv
// Bench for vterm: FIFO and RAM models, vector table, directed
// corner sequences and a random byte stream against a screen model.
module tb_vterm;

  localparam int S     = 128;
  localparam int W     = 80;
  localparam int H     = 56;
  localparam int AW    = 13;
  localparam int TW    = 4;
  localparam int MEM   = 1 << AW;
  localparam int LINE  = (H - 1) * S;
  localparam logic [7:0]  ATTR   = 8'h1F;
  localparam logic [15:0] BLANKC = 16'h1F20;
  localparam logic [15:0] INITV  = 16'h0E2E;
  localparam int SCROLL_CLK = (H - 1) * S + 1 + W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rdata = 8'h00;
  logic          rdempty = 1'b1;
  logic          ack;
  logic [AW-1:0] radr;
  logic [15:0]   q = 16'h0;
  logic [AW-1:0] wadr;
  logic [15:0]   wdata;
  logic          wr;
  logic [AW-1:0] cursor_adr;
  logic          busy;

  vterm dut (
    .clk        (clk),
    .reset      (reset),
    .rdata      (rdata),
    .rdempty    (rdempty),
    .ack        (ack),
    .radr       (radr),
    .q          (q),
    .wadr       (wadr),
    .wdata      (wdata),
    .wr         (wr),
    .cursor_adr (cursor_adr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0]   mem [MEM];
  logic [15:0]   exp_mem [MEM];
  logic [7:0]    fifo [$];
  logic          ack_q = 1'b0;
  int            ack_cnt = 0;
  int            busy_cnt = 0;
  int            wr_cnt = 0;
  int            ab_err = 0;
  logic [AW-1:0] last_wadr = '0;
  logic [15:0]   last_wdata = '0;
  logic          poke_req = 1'b0;
  int            poke_lo = 0;
  int            poke_hi = 0;
  logic [15:0]   poke_val = '0;
  int            tests = 0;
  int            fails = 0;
  int            mcol = 0;

  always @(posedge clk) begin
    ack_q <= ack;
    if (ack) ack_cnt <= ack_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (ack && busy) ab_err <= ab_err + 1;
    q <= mem[radr];
    if (wr) begin
      mem[wadr]  <= wdata;
      wr_cnt     <= wr_cnt + 1;
      last_wadr  <= wadr;
      last_wdata <= wdata;
    end
    if (poke_req)
      for (int a = poke_lo; a <= poke_hi; a++) mem[a] <= poke_val;
  end

  always @(negedge clk) begin
    logic [7:0] d;
    if (ack_q && fifo.size() > 0) d = fifo.pop_front();
    rdempty = (fifo.size() == 0);
    rdata   = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic poke(input int lo, input int hi, input logic [15:0] v);
    @(negedge clk);
    poke_lo = lo; poke_hi = hi; poke_val = v; poke_req = 1'b1;
    @(negedge clk);
    poke_req = 1'b0;
    for (int a = lo; a <= hi; a++) exp_mem[a] = v;
  endtask

  task automatic m_scroll();
    for (int a = 0; a < (H - 1) * S; a++) exp_mem[a] = exp_mem[a + S];
    for (int k = 0; k < W; k++) exp_mem[LINE + k] = BLANKC;
  endtask

  // screen rules applied directly to the expected picture
  task automatic model(input logic [7:0] b);
    if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) m_scroll();
    else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      for (int a = 0; a < H * S; a++) exp_mem[a] = BLANKC;
      mcol = 0;
    end else begin
      exp_mem[LINE + mcol] = {ATTR, (b == 8'h09) ? 8'h20 : b};
      if (b == 8'h09) mcol = (mcol / TW + 1) * TW;
      else mcol++;
      if (mcol > W) mcol = W;
      if (mcol == W) begin
        mcol = 0;
        m_scroll();
      end
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((fifo.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, n < budget, 1);
  endtask

  task automatic send_wait(input logic [7:0] b);
    fifo.push_back(b);
    model(b);
    wait_idle("send", 10000);
  endtask

  task automatic cmp_screen(input string nm);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int a = 0; a < MEM; a++)
      if (mem[a] !== exp_mem[a]) begin
        if (first < 0) first = a;
        bad++;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d bad cells, first @%0h got %0h required %0h",
               nm, bad, first, mem[first], exp_mem[first]);
    end
  endtask

  typedef struct {
    logic [7:0]  b;
    int          col;
    int          nwr;
    logic [AW-1:0] adr;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int a0, w0, b0;
    logic [7:0] rb;

    tbl[0]  = '{8'h08, 0, 0, 13'h0,    16'h0};
    tbl[1]  = '{8'h41, 1, 1, 13'h1B80, 16'h1F41};
    tbl[2]  = '{8'h42, 2, 1, 13'h1B81, 16'h1F42};
    tbl[3]  = '{8'h08, 1, 0, 13'h0,    16'h0};
    tbl[4]  = '{8'h43, 2, 1, 13'h1B81, 16'h1F43};
    tbl[5]  = '{8'h0D, 0, 0, 13'h0,    16'h0};
    tbl[6]  = '{8'h09, 4, 1, 13'h1B80, 16'h1F20};
    tbl[7]  = '{8'h71, 5, 1, 13'h1B84, 16'h1F71};
    tbl[8]  = '{8'h09, 8, 1, 13'h1B85, 16'h1F20};
    tbl[9]  = '{8'h08, 7, 0, 13'h0,    16'h0};
    tbl[10] = '{8'h09, 8, 1, 13'h1B87, 16'h1F20};
    tbl[11] = '{8'h0D, 0, 0, 13'h0,    16'h0};

    poke(0, MEM - 1, INITV);
    #1;
    check("rst_wr", wr, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_wadr", wadr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_radr", radr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cursor", cursor_adr, LINE);
    check("idle_busy", busy, 0);

    // vector table
    a0 = ack_cnt;
    foreach (tbl[i]) begin
      w0 = wr_cnt;
      send_wait(tbl[i].b);
      check($sformatf("tbl%0d_cursor", i), cursor_adr, LINE + tbl[i].col);
      check($sformatf("tbl%0d_nwr", i), wr_cnt - w0, tbl[i].nwr);
      if (tbl[i].nwr == 1) begin
        check($sformatf("tbl%0d_wadr", i), last_wadr, tbl[i].adr);
        check($sformatf("tbl%0d_wdata", i), last_wdata, tbl[i].dat);
      end
    end
    check("tbl_acks", ack_cnt - a0, 12);
    cmp_screen("tbl_screen");

    // LF scroll with a preloaded line 1
    poke(S, 2 * S - 1, 16'h1F31);
    send_wait(8'h41);
    send_wait(8'h42);
    b0 = busy_cnt;
    w0 = wr_cnt;
    send_wait(8'h0A);
    check("lf_busy_clk", busy_cnt - b0, 1 + SCROLL_CLK);
    check("lf_writes", wr_cnt - w0, (H - 1) * S + W);
    check("lf_cursor", cursor_adr, LINE + 2);
    check("lf_line0", mem[0], 16'h1F31);
    check("lf_line0_hidden", mem[S - 1], 16'h1F31);
    check("lf_moved_A", mem[LINE - S], 16'h1F41);
    check("lf_fill79", mem[LINE + W - 1], BLANKC);
    check("lf_nofill80", mem[LINE + W], INITV);
    cmp_screen("lf_screen");

    // TAB at the last column wraps
    send_wait(8'h0D);
    for (int i = 0; i < W - 1; i++) send_wait(8'h78);
    check("wrap_pre_cursor", cursor_adr, LINE + W - 1);
    send_wait(8'h09);
    check("wrap_cursor", cursor_adr, LINE);
    check("wrap_tabcell", mem[LINE - S + W - 1], BLANKC);
    check("wrap_xcell", mem[LINE - S], 16'h1F78);
    send_wait(8'h79);
    check("wrap_y_wadr", last_wadr, 13'h1B80);
    check("wrap_y_wdata", last_wdata, 16'h1F79);
    cmp_screen("wrap_screen");

    // FF with bytes queued behind it
    a0 = ack_cnt;
    w0 = wr_cnt;
    b0 = ab_err;
    fifo.push_back(8'h0C); model(8'h0C);
    fifo.push_back(8'h31); model(8'h31);
    fifo.push_back(8'h32); model(8'h32);
    fifo.push_back(8'h33); model(8'h33);
    wait_idle("ff", 12000);
    check("ff_writes", wr_cnt - w0, H * S + 3);
    check("ff_acks", ack_cnt - a0, 4);
    check("ff_ack_busy", ab_err - b0, 0);
    check("ff_cursor", cursor_adr, LINE + 3);
    cmp_screen("ff_screen");

    // reset in the middle of a scroll, byte waiting
    fifo.push_back(8'h0A);
    repeat (200) @(negedge clk);
    check("mid_busy", busy, 1);
    fifo.push_back(8'h5A);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_wr", wr, 0);
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    check("abort_radr", radr, 0);
    @(negedge clk);
    @(negedge clk);
    check("abort_ack_held", ack, 0);
    reset = 1'b0;
    mcol = 0;
    model(8'h5A);
    wait_idle("abort", 200);
    check("abort_z_wadr", last_wadr, 13'h1B80);
    check("abort_z_wdata", last_wdata, 16'h1F5A);
    check("abort_cursor", cursor_adr, LINE + 1);

    // resync the picture, then a random stream
    send_wait(8'h0C);
    cmp_screen("resync_screen");
    for (int i = 0; i < 70; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) rb = 8'h0A;
      else if (r < 8) rb = 8'h0D;
      else if (r < 14) rb = 8'h08;
      else if (r < 24) rb = 8'h09;
      else rb = 8'($urandom_range(8'h21, 8'h7E));
      fifo.push_back(rb);
      model(rb);
    end
    b0 = ab_err;
    wait_idle("rand", 60000);
    check("rand_cursor", cursor_adr, LINE + mcol);
    check("rand_ack_busy", ab_err - b0, 0);
    cmp_screen("rand_screen");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
